countdown_ctrl: RTL

//  Control stage directly upstream of the cascaded BCD/mod-6 down-counter chain in the countdown timer.

---
 rtl/countdown_ctrl_if.sv | 17 +
 rtl/countdown_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl_if.sv
// Pin bundle between countdown_ctrl and the surrounding timer logic.
// Signal names follow the timer's original pin names.
interface countdown_ctrl_if;
    logic       START;
    logic       CLEAR;
    logic       ZERO;
    logic       EN;
    logic       LOAD;
    logic       RUNNING;
    logic       ALARM;
    logic [1:0] STATE;

    modport master (output START, CLEAR, ZERO,
                    input  EN, LOAD, RUNNING, ALARM, STATE);
    modport slave  (input  START, CLEAR, ZERO,
                    output EN, LOAD, RUNNING, ALARM, STATE);
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: control stage ahead of the BCD/mod-6 down-counter chain.
// Synchronises and edge-detects the START/CLEAR buttons, runs the
// IDLE/RUN/PAUSE/ALARM machine, prescales the clock into count-enable
// pulses and times the alarm.
// Optional feature macro: AUTO_RELOAD_EN (alarm timeout reloads the chain
// and restarts counting instead of returning to IDLE).
module countdown_ctrl #(
    parameter int unsigned DIV         = 50_000_000,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic            CLOCK,
    input  logic            RESET,
    countdown_ctrl_if.slave bus
);
    localparam int unsigned   PW       = $clog2(DIV);
    localparam int unsigned   AW       = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    start_sync_q, clear_sync_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [AW-1:0] alm_q, alm_d;
    logic          en_q, en_d;
    logic          load_q, load_d;
    logic          running_q, alarm_q;
    logic          start_p, clear_p, zero_eff, tick;

    // Stages [1:0] are the 2-FF synchroniser, stage [2] holds the previous level.
    assign start_p = start_sync_q[1] & ~start_sync_q[2];
    assign clear_p = clear_sync_q[1] & ~clear_sync_q[2];

    assign tick = ((state_q == S_RUN) || (state_q == S_ALARM)) && (pre_q == PRE_LAST);

`ifdef AUTO_RELOAD_EN
    // The chain still reads 00:00 in the cycle after LOAD; ignore it until reloaded.
    assign zero_eff = bus.ZERO & ~load_q;
`else
    assign zero_eff = bus.ZERO;
`endif

    // Button synchronisers and edge-detect history.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            start_sync_q <= '0;
            clear_sync_q <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], bus.START};
            clear_sync_q <= {clear_sync_q[1:0], bus.CLEAR};
        end
    end

    // Next state, prescaler/alarm counter updates and output pulses.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        alm_d   = alm_q;
        en_d    = 1'b0;
        load_d  = 1'b0;

        if ((state_q == S_RUN) || (state_q == S_ALARM)) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (clear_p) begin
                    load_d = 1'b1;
                end else if (start_p && !zero_eff) begin
                    state_d = S_RUN;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                en_d = tick && !clear_p && !zero_eff;
                if (clear_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (zero_eff) begin
                    state_d = S_ALARM;
                    pre_d   = '0;
                end else if (start_p) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (clear_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (start_p) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (tick) begin
                    alm_d = alm_q + 1'b1;
                end
                if (clear_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (start_p) begin
                    state_d = S_IDLE;
                end else if (tick && (alm_q == ALM_LAST)) begin
`ifdef AUTO_RELOAD_EN
                    state_d = S_RUN;
                    load_d  = 1'b1;
                    pre_d   = '0;
`else
                    state_d = S_IDLE;
`endif
                end
                if (state_d != S_ALARM) begin
                    alm_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            alm_q     <= '0;
            en_q      <= 1'b0;
            load_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            alm_q     <= alm_d;
            en_q      <= en_d;
            load_q    <= load_d;
            running_q <= (state_d == S_RUN);
            alarm_q   <= (state_d == S_ALARM);
        end
    end

    assign bus.EN      = en_q;
    assign bus.LOAD    = load_q;
    assign bus.RUNNING = running_q;
    assign bus.ALARM   = alarm_q;
    assign bus.STATE   = state_q;
endmodule
